vid_sprite_linebuf_reader: RTL

Scan-out stage for the sprite line buffer. It reads the half of the 2048×9 dual-port buffer that the sprite renderer finished on the previous line, one pixel per request, and delivers pixels to the video mixer. Each read also clears that location, so the half is empty when the renderer gets it back. After reset or on request, it flushes the whole buffer to the transparent value.

---
 rtl/vid_sprite_linebuf_reader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/vid_sprite_linebuf_reader.sv
// Sprite line-buffer scan-out: reads one half per line with optional clear-on-read,
// and flushes the whole buffer to the transparent value after reset or on request.
module vid_sprite_linebuf_reader #(
    parameter int               LINE_BITS = 10,
    parameter int               PIX_W     = 9,
    parameter logic [PIX_W-1:0] CLEAR_VAL = 9'h000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 line_start,
    input  logic                 pix_req,
    input  logic                 clear_en,
    input  logic                 flush_req,
    output logic [PIX_W-1:0]     pix_out,
    output logic                 pix_valid,
    output logic                 rd_half,
    output logic                 overrun,
    output logic                 busy,
    output logic [LINE_BITS:0]   lb_addr,
    output logic                 lb_en,
    output logic                 lb_wr,
    output logic [PIX_W-1:0]     lb_wdata,
    input  logic [PIX_W-1:0]     lb_rdata
);

    localparam int AW = LINE_BITS + 1;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [AW-1:0]         r_flush_cnt, w_flush_cnt_nxt;
    logic [LINE_BITS-1:0]  r_x, w_x_cur, w_x_nxt;
    logic                  r_rd_half, w_half_cur;
    logic                  r_overrun, w_overrun_nxt;
    logic                  w_issue_rd, w_issue_flush;
    logic [AW-1:0]         w_addr_nxt;

    logic [AW-1:0]         r_lb_addr;
    logic                  r_lb_en, r_lb_wr;
    logic                  r_rd_p1, r_rd_p2;
    logic [PIX_W-1:0]      r_pix_out;
    logic                  r_pix_valid;

    // NOTE: every variable gets a default first, so no path through this block can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_half_cur      = line_start ? ~r_rd_half : r_rd_half;
        w_x_cur         = line_start ? '0 : r_x;
        w_x_nxt         = w_x_cur;
        w_overrun_nxt   = line_start ? 1'b0 : r_overrun;
        w_issue_rd      = 1'b0;
        w_issue_flush   = 1'b0;
        w_addr_nxt      = '0;

        // A flush request outranks everything, including a same-cycle pixel request.
        if (flush_req) begin
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    w_issue_flush   = 1'b1;
                    w_addr_nxt      = r_flush_cnt;
                    w_flush_cnt_nxt = r_flush_cnt + AW'(1);
                    if (&r_flush_cnt) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pix_req) begin
                        w_issue_rd = 1'b1;
                        w_addr_nxt = {w_half_cur, w_x_cur};
                        w_x_nxt    = w_x_cur + LINE_BITS'(1);
                        if (&w_x_cur) begin
                            w_overrun_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_FLUSH;
            endcase
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= '0;
            r_x         <= '0;
            r_rd_half   <= 1'b0;
            r_overrun   <= 1'b0;
            r_lb_addr   <= '0;
            r_lb_en     <= 1'b0;
            r_lb_wr     <= 1'b0;
            r_rd_p1     <= 1'b0;
            r_rd_p2     <= 1'b0;
            r_pix_out   <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_x         <= w_x_nxt;
            r_rd_half   <= w_half_cur;
            r_overrun   <= w_overrun_nxt;
            r_lb_en     <= w_issue_rd | w_issue_flush;
            r_lb_wr     <= w_issue_flush | (w_issue_rd & clear_en);
            if (w_issue_rd || w_issue_flush) begin
                r_lb_addr <= w_addr_nxt;
            end
            // Address registered, RAM samples next edge, data captured the edge after.
            r_rd_p1     <= w_issue_rd;
            r_rd_p2     <= r_rd_p1;
            r_pix_valid <= r_rd_p2;
            if (r_rd_p2) begin
                r_pix_out <= lb_rdata;
            end
        end
    end

    assign pix_out   = r_pix_out;
    assign pix_valid = r_pix_valid;
    assign rd_half   = r_rd_half;
    assign overrun   = r_overrun;
    assign busy      = (r_state == ST_FLUSH);
    assign lb_addr   = r_lb_addr;
    assign lb_en     = r_lb_en;
    assign lb_wr     = r_lb_wr;
    assign lb_wdata  = CLEAR_VAL;

endmodule
